// File: rtl/dca_tensor_scalar_result_buffer.sv
// Result FIFO with launch credits for the tensor-scalar add/sub unit (no backpressure upstream).
// Optional status ports (overflow, occupancy) are enabled by defining DCA_RESULT_BUFFER_STATUS_EN.
module dca_tensor_scalar_result_buffer #(
    parameter int BW_DATA      = 32,
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic                     in_valid,
    input  logic [BW_DATA-1:0]       in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BW_DATA-1:0]       out_result
`ifdef DCA_RESULT_BUFFER_STATUS_EN
    ,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   occupancy
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Inflight can never exceed DEPTH because credits cap count + inflight.
    localparam int IW = $clog2(DEPTH + MAX_INFLIGHT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [BW_DATA-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [IW-1:0]      r_inflight;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_ovf;
    logic               w_write;
    logic               w_fire;
    logic [SW-1:0]      w_sum;

    assign w_sum       = SW'(r_count) + SW'(r_inflight);
    assign issue_ready = (w_sum < SW'(DEPTH));
    assign out_valid   = (r_count != '0);
    assign out_result  = r_mem[r_rd_ptr];

    assign w_push  = in_valid & enable;
    assign w_pop   = out_valid & out_ready;
    assign w_fire  = issue_valid & issue_ready & enable;
    assign w_full  = (r_count == CW'(DEPTH));
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign w_ovf   = w_push & w_full & ~w_pop;
    assign w_write = w_push & ~w_ovf;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!clear && w_write) begin
            r_mem[r_wr_ptr] <= in_result;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Same-cycle launch and arrival (integer mode) cancel; unsolicited arrivals never underflow.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_inflight <= '0;
        end else if (clear) begin
            r_inflight <= '0;
        end else if (w_fire && !w_write) begin
            r_inflight <= r_inflight + IW'(1);
        end else if (w_write && !w_fire && (r_inflight != '0)) begin
            r_inflight <= r_inflight - IW'(1);
        end
    end

`ifdef DCA_RESULT_BUFFER_STATUS_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (w_ovf) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign occupancy = r_count;
`endif

endmodule

// File: tb/tb_dca_tensor_scalar_result_buffer.sv
// Directed bench for dca_tensor_scalar_result_buffer: a vector table plus hand-written
// multi-cycle sequences (float-mode credits, full push+pop, enable hold, overflow, reset).
module tb_dca_tensor_scalar_result_buffer;

    localparam int BW = 32;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rstnn;
    logic          enable;
    logic          clear;
    logic          issue_valid;
    logic          issue_ready;
    logic          in_valid;
    logic [BW-1:0] in_result;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_result;
`ifdef DCA_RESULT_BUFFER_STATUS_EN
    logic          overflow;
    logic [3:0]    occupancy;
`endif

    int n_checks;
    int n_fail;

    dca_tensor_scalar_result_buffer #(
        .BW_DATA(BW), .DEPTH(DEPTH), .MAX_INFLIGHT(3)
    ) dut (
        .clk(clk), .rstnn(rstnn), .enable(enable), .clear(clear),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .in_valid(in_valid), .in_result(in_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef DCA_RESULT_BUFFER_STATUS_EN
        , .overflow(overflow), .occupancy(occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          iv;
        logic          inv;
        logic [BW-1:0] res;
        logic          en;
        logic          clr;
        logic          ordy;
        logic          e_ov;
        logic [BW-1:0] e_or;
        logic          e_ir;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic inv, input logic [BW-1:0] res,
                         input logic en, input logic clr, input logic ordy);
        issue_valid = iv;
        in_valid    = inv;
        in_result   = res;
        enable      = en;
        clear       = clr;
        out_ready   = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [BW-1:0] base);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 1'b1, base + BW'(k), 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name, input logic [BW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            check({name, "_valid"}, BW'(out_valid), BW'(1));
            check({name, "_data"}, out_result, base + BW'(k));
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input string name, input logic iv, input logic inv,
                                input logic [BW-1:0] res, input logic en, input logic clr,
                                input logic ordy, input logic e_ov, input logic [BW-1:0] e_or,
                                input logic e_ir);
        vec_t v;
        v.name = name; v.iv = iv; v.inv = inv; v.res = res; v.en = en; v.clr = clr;
        v.ordy = ordy; v.e_ov = e_ov; v.e_or = e_or; v.e_ir = e_ir;
        return v;
    endfunction

    logic          pv [3];
    logic [BW-1:0] pd [3];
    logic          fire;
    int            n_fire;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Expected outputs are the state after the edge that applies each row.
        vecs[0] = mk("idle",        0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  1);
        vecs[1] = mk("int_mode",    1, 1, 32'h5,  1, 0, 0, 1, 32'h5,  1);
        vecs[2] = mk("pop_to_empty",0, 0, 32'h0,  1, 0, 1, 0, 32'h0,  1);
        vecs[3] = mk("unsolicited", 0, 1, 32'h33, 1, 0, 0, 1, 32'h33, 1);
        vecs[4] = mk("enable_low",  1, 1, 32'h44, 0, 0, 0, 1, 32'h33, 1);
        vecs[5] = mk("clear_prio",  1, 1, 32'h55, 1, 1, 1, 0, 32'h5,  1);
        vecs[6] = mk("after_clear", 0, 1, 32'h66, 1, 0, 0, 1, 32'h66, 1);
        vecs[7] = mk("pop_again",   0, 0, 32'h0,  1, 0, 1, 0, 32'h33, 1);

        rstnn = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("rst_out_valid",   BW'(out_valid),   BW'(0));
        check("rst_out_result",  out_result,       BW'(0));
        check("rst_issue_ready", BW'(issue_ready), BW'(1));
`ifdef DCA_RESULT_BUFFER_STATUS_EN
        check("rst_occupancy",   BW'(occupancy),   BW'(0));
        check("rst_overflow",    BW'(overflow),    BW'(0));
`endif
        rstnn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].iv, vecs[i].inv, vecs[i].res, vecs[i].en, vecs[i].clr, vecs[i].ordy);
            step();
            check({vecs[i].name, "_out_valid"},   BW'(out_valid),   BW'(vecs[i].e_ov));
            check({vecs[i].name, "_out_result"},  out_result,       vecs[i].e_or);
            check({vecs[i].name, "_issue_ready"}, BW'(issue_ready), BW'(vecs[i].e_ir));
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Float mode: launches return three edges later, consumer stalled.
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end
        n_fire = 0;
        for (int c = 0; c < 20; c++) begin
            fire = issue_ready;
            drive(1'b1, pv[2], pd[2], 1'b1, 1'b0, 1'b0);
            step();
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = fire;  pd[0] = 32'h100 + BW'(n_fire);
            if (fire) n_fire++;
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("float_fire_count",  BW'(n_fire),      BW'(8));
        check("float_issue_ready", BW'(issue_ready), BW'(0));
`ifdef DCA_RESULT_BUFFER_STATUS_EN
        check("float_occupancy",   BW'(occupancy),   BW'(8));
`endif
        drain("float_pop", 32'h100, 8);
        check("float_empty",       BW'(out_valid),   BW'(0));
        check("float_credit_back", BW'(issue_ready), BW'(1));

        // Full FIFO: push and pop in the same cycle.
        fill(32'h200);
        check("full_issue_ready", BW'(issue_ready), BW'(0));
        drive(1'b0, 1'b1, 32'hA, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("full_pp_ready",    BW'(issue_ready), BW'(0));
`ifdef DCA_RESULT_BUFFER_STATUS_EN
        check("full_pp_occupancy", BW'(occupancy), BW'(8));
`endif
        drain("full_pp", 32'h201, 7);
        drain("full_pp_new", 32'hA, 1);
        check("full_pp_empty", BW'(out_valid), BW'(0));

        // enable low: arrivals ignored, consumer keeps draining.
        fill(32'h400);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'hEE, 1'b0, 1'b0, 1'b1);
            step();
            check("en_low_head", out_result, 32'h401 + BW'(k));
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("en_low_issue_ready", BW'(issue_ready), BW'(1));
        drain("en_low_rest", 32'h404, 4);
        check("en_low_empty", BW'(out_valid), BW'(0));

        // Overflow: credit-violating push is dropped.
        fill(32'h300);
        drive(1'b0, 1'b1, 32'hBB, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("ovf_head", out_result, 32'h300);
`ifdef DCA_RESULT_BUFFER_STATUS_EN
        check("ovf_flag",      BW'(overflow),  BW'(1));
        check("ovf_occupancy", BW'(occupancy), BW'(8));
`endif
        drain("ovf_keep", 32'h300, 8);
        check("ovf_dropped", BW'(out_valid), BW'(0));

        fill(32'h500);
        drive(1'b0, 1'b1, 32'hCC, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("clr_out_valid",   BW'(out_valid),   BW'(0));
        check("clr_issue_ready", BW'(issue_ready), BW'(1));
`ifdef DCA_RESULT_BUFFER_STATUS_EN
        check("clr_overflow",    BW'(overflow),    BW'(0));
`endif

        // Asynchronous reset mid-operation.
        drive(1'b1, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("pre_rst_valid", BW'(out_valid), BW'(1));
        #2;
        rstnn = 1'b0;
        #1;
        check("async_rst_valid",  BW'(out_valid),  BW'(0));
        check("async_rst_result", out_result,      BW'(0));
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        rstnn = 1'b1;
        step();
        check("post_rst_ready", BW'(issue_ready), BW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
